// File: rtl/shift_stack.sv
// Bidirectional byte shift register used as a LIFO stack: push shifts away from the head,
// pop shifts back toward it, so the most recently pushed byte is always at stage 0.
module shift_stack #(
   parameter  int DEPTH = 16,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    data_in,
   input  logic          clear_err,
   output logic [7:0]    data_out,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          overflow,
   output logic          underflow
);

   localparam logic [CW-1:0] FullCount = CW'(DEPTH);

   logic [DEPTH-1:0][7:0] stage_q, stage_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  isEmpty, isFull;

   assign isEmpty = (count_q == '0);
   assign isFull  = (count_q == FullCount);

   always_comb begin
      stage_d     = stage_q;
      count_d     = count_q;
      overflow_d  = overflow_q & ~clear_err;
      underflow_d = underflow_q & ~clear_err;

      unique case ({push, pop})
         2'b10: begin
            stage_d[0] = data_in;
            for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
            if (isFull) overflow_d = 1'b1;
            else        count_d    = count_q + CW'(1);
         end
         2'b01: begin
            if (isEmpty) begin
               underflow_d = 1'b1;
            end else begin
               for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
               stage_d[DEPTH-1] = '0;
               count_d          = count_q - CW'(1);
            end
         end
         2'b11: begin
            // Simultaneous push/pop replaces the top; on an empty stack it degenerates to a push.
            stage_d[0] = data_in;
            if (isEmpty) count_d = CW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q     <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         stage_q     <= stage_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign data_out  = stage_q[0];
   assign count     = count_q;
   assign empty     = isEmpty;
   assign full      = isFull;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_shift_stack.sv
// Bench for shift_stack at DEPTH=4: directed vector table, mid-cycle reset sequence,
// and random traffic checked against a queue-based LIFO model.
module tb_shift_stack;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          push = 1'b0, pop = 1'b0, clear_err = 1'b0;
   logic [7:0]    data_in = '0;
   logic [7:0]    data_out;
   logic [CW-1:0] count;
   logic          empty, full, overflow, underflow;

   int total = 0;
   int bad   = 0;

   shift_stack #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .data_in(data_in),
      .clear_err(clear_err), .data_out(data_out), .count(count), .empty(empty),
      .full(full), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       push;
      logic       pop;
      logic       clr;
      logic [7:0] din;
      logic [7:0] dout;
      int         cnt;
      logic       emp;
      logic       ful;
      logic       ovf;
      logic       unf;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(logic p, logic q, logic c, logic [7:0] d, logic [7:0] o,
                                  int n, logic e, logic f, logic ov, logic un);
      vec_t v;
      v.push = p; v.pop = q; v.clr = c; v.din = d; v.dout = o;
      v.cnt = n; v.emp = e; v.ful = f; v.ovf = ov; v.unf = un;
      vecs.push_back(v);
   endfunction

   // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
   task automatic applyStimulus(input logic p, input logic q, input logic c, input logic [7:0] d);
      @(negedge clk);
      push = p; pop = q; clear_err = c; data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] expD, input int expC,
                              input logic expE, input logic expF, input logic expO, input logic expU);
      logic [7:0] expCount;
      expCount = 8'(expC);
      total++;
      if (data_out !== expD || {5'b0, count} !== expCount || empty !== expE ||
          full !== expF || overflow !== expO || underflow !== expU) begin
         bad++;
         $display("[TB] FAIL %s: got dout=%h cnt=%0d e=%b f=%b ov=%b un=%b, want dout=%h cnt=%0d e=%b f=%b ov=%b un=%b",
                  name, data_out, count, empty, full, overflow, underflow,
                  expD, expC, expE, expF, expO, expU);
      end
   endtask

   // Reference model: queue with the top of stack at index 0.
   logic [7:0] model[$];
   logic       mOvf, mUnf;

   task automatic modelStep(input logic p, input logic q, input logic c, input logic [7:0] d);
      logic ovEv, unEv;
      ovEv = 1'b0; unEv = 1'b0;
      if (p && !q) begin
         model.push_front(d);
         if (model.size() > DEPTH) begin
            void'(model.pop_back());
            ovEv = 1'b1;
         end
      end else if (!p && q) begin
         if (model.size() == 0) unEv = 1'b1;
         else void'(model.pop_front());
      end else if (p && q) begin
         if (model.size() == 0) model.push_front(d);
         else model[0] = d;
      end
      mOvf = (mOvf & ~c) | ovEv;
      mUnf = (mUnf & ~c) | unEv;
   endtask

   initial begin
      // Test plan steps 1-5 as a flat vector stream starting from reset.
      addVec(1,0,0,8'h11, 8'h11,1,0,0,0,0);
      addVec(1,0,0,8'h22, 8'h22,2,0,0,0,0);
      addVec(1,0,0,8'h33, 8'h33,3,0,0,0,0);
      addVec(0,1,0,8'h00, 8'h22,2,0,0,0,0);
      addVec(0,1,0,8'h00, 8'h11,1,0,0,0,0);
      addVec(0,1,0,8'h00, 8'h00,0,1,0,0,0);
      addVec(1,0,0,8'hA1, 8'hA1,1,0,0,0,0);
      addVec(1,0,0,8'hA2, 8'hA2,2,0,0,0,0);
      addVec(1,0,0,8'hA3, 8'hA3,3,0,0,0,0);
      addVec(1,0,0,8'hA4, 8'hA4,4,0,1,0,0);
      addVec(1,0,0,8'hA5, 8'hA5,4,0,1,1,0);
      addVec(0,1,0,8'h00, 8'hA4,3,0,0,1,0);
      addVec(0,1,0,8'h00, 8'hA3,2,0,0,1,0);
      addVec(0,1,0,8'h00, 8'hA2,1,0,0,1,0);
      addVec(0,1,0,8'h00, 8'h00,0,1,0,1,0);
      addVec(0,1,0,8'h00, 8'h00,0,1,0,1,1);
      addVec(0,0,1,8'h00, 8'h00,0,1,0,0,0);
      addVec(0,1,1,8'h00, 8'h00,0,1,0,0,1);
      addVec(0,0,1,8'h00, 8'h00,0,1,0,0,0);
      addVec(1,0,0,8'h55, 8'h55,1,0,0,0,0);
      addVec(1,0,0,8'h66, 8'h66,2,0,0,0,0);
      addVec(1,1,0,8'h77, 8'h77,2,0,0,0,0);
      addVec(0,1,0,8'h00, 8'h55,1,0,0,0,0);
      addVec(0,1,0,8'h00, 8'h00,0,1,0,0,0);
      addVec(1,1,0,8'h99, 8'h99,1,0,0,0,0);
      addVec(1,1,0,8'h5A, 8'h5A,1,0,0,0,0);

      #12;
      checkOutput("reset", 8'h00, 0, 1, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
         checkOutput($sformatf("vec%0d", i), vecs[i].dout, vecs[i].cnt,
                     vecs[i].emp, vecs[i].ful, vecs[i].ovf, vecs[i].unf);
      end

      // Mid-cycle asynchronous reset with live data and a set flag.
      applyStimulus(0,1,0,8'h00);
      applyStimulus(0,1,0,8'h00);
      checkOutput("preUnf", 8'h00, 0, 1, 0, 0, 1);
      applyStimulus(1,0,0,8'hDE);
      applyStimulus(1,0,0,8'hAD);
      checkOutput("prePush", 8'hAD, 2, 0, 0, 0, 1);
      #3;
      rst_n = 1'b0;
      push = 1'b0; pop = 1'b0; clear_err = 1'b0; data_in = '0;
      #1;
      checkOutput("asyncRst", 8'h00, 0, 1, 0, 0, 0);
      #1;
      rst_n = 1'b1;
      applyStimulus(0,0,0,8'h00);
      checkOutput("postRstIdle", 8'h00, 0, 1, 0, 0, 0);
      applyStimulus(0,1,0,8'h00);
      checkOutput("postRstPop", 8'h00, 0, 1, 0, 0, 1);

      // Random traffic against the model, starting from a fresh reset.
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model.delete();
      mOvf = 1'b0; mUnf = 1'b0;
      for (int n = 0; n < 400; n++) begin
         logic p, q, c;
         logic [7:0] d;
         logic [7:0] expD;
         p = 1'($urandom_range(0, 1));
         q = 1'($urandom_range(0, 1));
         c = ($urandom_range(0, 9) == 0);
         d = 8'($urandom);
         applyStimulus(p, q, c, d);
         modelStep(p, q, c, d);
         expD = (model.size() > 0) ? model[0] : 8'h00;
         checkOutput($sformatf("rand%0d", n), expD, model.size(), model.size() == 0,
                     model.size() == DEPTH, mOvf, mUnf);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
